contador_cm_uc: RTL and testbench

//  Control unit for the cm-counting datapath (tick prescaler + 3-digit BCD counter).
//  - Converts one measurement request plus the echo pulse of the ultrasonic sensor

---
 rtl/contador_cm_uc_pkg.sv | 38 +++
 rtl/sincronizador_2ff.sv | 21 ++
 rtl/contador_cm_uc.sv | 92 +++++++++
 tb/tb_contador_cm_uc.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/contador_cm_uc_pkg.sv
// rtl/contador_cm_uc_pkg.sv - state codes and Moore output decode for the cm-counter control unit
package contador_cm_uc_pkg;

    // Codes are shared with the sensor FSM and the 7-seg debug decode.
    typedef enum logic [3:0] {
        INICIAL = 4'h0,
        PREPARA = 4'h1,
        AGUARDA = 4'h2,
        MEDE    = 4'h3,
        FINAL   = 4'h4,
        ERRO    = 4'hE
    } estado_t;

    typedef struct packed {
        logic zera_tick;
        logic zera_bcd;
        logic conta_tick;
        logic pronto;
        logic ocupado;
    } saidas_t;

    function automatic saidas_t decodifica(input estado_t estado);
        saidas_t s;
        s = '0;
        s.ocupado = (estado != INICIAL);
        case (estado)
            PREPARA: begin
                s.zera_tick = 1'b1;
                s.zera_bcd  = 1'b1;
            end
            MEDE:    s.conta_tick = 1'b1;
            FINAL:   s.pronto     = 1'b1;
            default: ;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// rtl/sincronizador_2ff.sv - two-flop synchronizer for a single asynchronous bit
module sincronizador_2ff (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/contador_cm_uc.sv
// rtl/contador_cm_uc.sv - control unit sequencing one echo measurement with timeout and overflow supervision
module contador_cm_uc
    import contador_cm_uc_pkg::*;
#(
    parameter int T_ESPERA = 1_000_000,
    parameter int T_ECO    = 1_500_000,
    parameter int NT       = 21
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       medir,
    input  logic       echo,
    input  logic       fim_bcd,
    output logic       zera_tick,
    output logic       zera_bcd,
    output logic       conta_tick,
    output logic       pronto,
    output logic       erro,
    output logic       ocupado,
    output logic [3:0] db_estado
);

    localparam logic [NT-1:0] LIM_ESPERA = NT'(T_ESPERA - 1);
    localparam logic [NT-1:0] LIM_ECO    = NT'(T_ECO - 1);
    localparam logic [NT-1:0] UM         = NT'(1);

    logic          echo_s;
    estado_t       estado;
    estado_t       prox;
    logic [NT-1:0] timer;
    saidas_t       saidas;

    sincronizador_2ff u_sinc_echo (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (echo),
        .q       (echo_s)
    );

    always_comb begin
        prox = estado;
        case (estado)
            INICIAL: if (medir) prox = PREPARA;
            PREPARA: prox = AGUARDA;
            AGUARDA: begin
                // A stale echo already high here counts as the rise.
                if (echo_s)                   prox = MEDE;
                else if (timer == LIM_ESPERA) prox = ERRO;
            end
            MEDE: begin
                // Overflow beats a simultaneous echo fall so no bogus distance is reported.
                if (fim_bcd)               prox = ERRO;
                else if (!echo_s)          prox = FINAL;
                else if (timer == LIM_ECO) prox = ERRO;
            end
            FINAL:   prox = INICIAL;
            ERRO:    prox = INICIAL;
            default: prox = INICIAL;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado <= INICIAL;
            timer  <= '0;
            saidas <= '0;
            erro   <= 1'b0;
        end else begin
            estado <= prox;
            saidas <= decodifica(prox);

            if (prox != estado)
                timer <= '0;
            else if ((estado == AGUARDA || estado == MEDE) && timer != '1)
                timer <= timer + UM;

            if (estado == INICIAL && prox == PREPARA)
                erro <= 1'b0;
            else if (prox == ERRO && estado != ERRO)
                erro <= 1'b1;
        end
    end

    assign zera_tick  = saidas.zera_tick;
    assign zera_bcd   = saidas.zera_bcd;
    assign conta_tick = saidas.conta_tick;
    assign pronto     = saidas.pronto;
    assign ocupado    = saidas.ocupado;
    assign db_estado  = estado;

endmodule

// File: tb/tb_contador_cm_uc.sv
// tb/tb_contador_cm_uc.sv - scoreboard bench for the cm-counter control unit
module tb_contador_cm_uc;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       medir = 1'b0;
    logic       echo = 1'b0;
    logic       fim_bcd = 1'b0;
    logic       zera_tick, zera_bcd, conta_tick, pronto, erro, ocupado;
    logic [3:0] db_estado;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        logic [23:0] path;
        int          aguarda;
        int          conta;
        int          zt;
        int          zb;
        int          npronto;
        logic        erro_prep;
        logic        erro_end;
    } txn_t;

    txn_t q[$];

    contador_cm_uc #(
        .T_ESPERA (20),
        .T_ECO    (30),
        .NT       (21)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .medir      (medir),
        .echo       (echo),
        .fim_bcd    (fim_bcd),
        .zera_tick  (zera_tick),
        .zera_bcd   (zera_bcd),
        .conta_tick (conta_tick),
        .pronto     (pronto),
        .erro       (erro),
        .ocupado    (ocupado),
        .db_estado  (db_estado)
    );

    always #5 clock = ~clock;

    task automatic check(input string nome, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", nome, got, exp);
        end
    endtask

    function automatic txn_t mk(input logic [23:0] path, input int aguarda, input int conta,
                                input int npronto, input logic erro_end);
        txn_t t;
        t.path = path;
        t.aguarda = aguarda;
        t.conta = conta;
        t.zt = 1;
        t.zb = 1;
        t.npronto = npronto;
        t.erro_prep = 1'b0;
        t.erro_end = erro_end;
        return t;
    endfunction

    // Monitor: builds a record per measurement and checks it when the unit returns idle.
    initial begin
        txn_t       cur;
        txn_t       e;
        logic       ativo;
        logic [3:0] ultimo;
        ativo = 1'b0;
        ultimo = 4'h0;
        cur = mk(24'h0, 0, 0, 0, 1'b0);
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                ativo = 1'b0;
            end else begin
                check("ocupado", {31'b0, ocupado}, {31'b0, db_estado != 4'h0});
                if (db_estado != 4'h0) begin
                    if (!ativo) begin
                        ativo = 1'b1;
                        cur = mk({20'h0, db_estado}, 0, 0, 0, 1'b0);
                        cur.zt = 0;
                        cur.zb = 0;
                        ultimo = db_estado;
                    end else if (db_estado != ultimo) begin
                        cur.path = {cur.path[19:0], db_estado};
                        ultimo = db_estado;
                    end
                    if (db_estado == 4'h2) cur.aguarda++;
                    cur.conta   += int'(conta_tick);
                    cur.zt      += int'(zera_tick);
                    cur.zb      += int'(zera_bcd);
                    cur.npronto += int'(pronto);
                    if (db_estado == 4'h1) cur.erro_prep = erro;
                end else if (ativo) begin
                    ativo = 1'b0;
                    cur.erro_end = erro;
                    if (q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL unexpected_txn: got path %0h expected none", cur.path);
                    end else begin
                        e = q.pop_front();
                        check("path",      {8'h0, cur.path},      {8'h0, e.path});
                        check("aguarda",   cur.aguarda,           e.aguarda);
                        check("conta",     cur.conta,             e.conta);
                        check("zera_tick", cur.zt,                e.zt);
                        check("zera_bcd",  cur.zb,                e.zb);
                        check("pronto",    cur.npronto,           e.npronto);
                        check("erro_prep", {31'b0, cur.erro_prep}, {31'b0, e.erro_prep});
                        check("erro_end",  {31'b0, cur.erro_end},  {31'b0, e.erro_end});
                    end
                end
            end
        end
    end

    // n counts cycles after medir drops; echo is high for n in [atraso, atraso+largura).
    task automatic medicao(input int atraso, input int largura, input int fim_at,
                           input int medir_at, input int n_total);
        @(posedge clock); #1 medir = 1'b1;
        @(posedge clock); #1 medir = 1'b0;
        for (int n = 1; n <= n_total; n++) begin
            @(posedge clock); #1;
            echo    = (n >= atraso) && (n < atraso + largura);
            fim_bcd = (n == fim_at);
            medir   = (n == medir_at);
        end
        echo = 1'b0;
        fim_bcd = 1'b0;
        medir = 1'b0;
        repeat (3) @(posedge clock);
        #1 check("drain", q.size(), 0);
        check("idle", {28'h0, db_estado}, 32'h0);
    endtask

    initial begin
        #2;
        check("reset_outs", {25'h0, zera_tick, zera_bcd, conta_tick, pronto, erro, ocupado, 1'b0},
              32'h0);
        check("reset_state", {28'h0, db_estado}, 32'h0);
        @(posedge clock);
        @(posedge clock); #1 reset_n = 1'b1;
        repeat (2) @(posedge clock);

        // Normal: echo_s high 12 cycles, 7 cycles waiting for it.
        q.push_back(mk(24'h001234, 7, 12, 1, 1'b0));
        medicao(5, 12, 0, 0, 40);

        // No echo: 20 cycles in AGUARDA then ERRO.
        q.push_back(mk(24'h00012E, 20, 0, 0, 1'b1));
        medicao(0, 0, 0, 0, 40);

        // Stuck echo: capped at 30 counting cycles; erro cleared again in PREPARA.
        q.push_back(mk(24'h00123E, 7, 30, 0, 1'b1));
        medicao(5, 40, 0, 0, 60);

        // Overflow in the cycle echo_s falls.
        q.push_back(mk(24'h00123E, 7, 12, 0, 1'b1));
        medicao(5, 12, 19, 0, 40);

        // medir during MEDE must be ignored.
        q.push_back(mk(24'h001234, 7, 12, 1, 1'b0));
        medicao(5, 12, 0, 10, 40);

        // Reset in the middle of MEDE.
        @(posedge clock); #1 medir = 1'b1;
        @(posedge clock); #1 medir = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clock); #1;
            echo = (n >= 5);
        end
        check("pre_reset_state", {28'h0, db_estado}, 32'h3);
        reset_n = 1'b0;
        #1;
        check("reset_mid_outs", {25'h0, zera_tick, zera_bcd, conta_tick, pronto, erro, ocupado, 1'b0},
              32'h0);
        check("reset_mid_state", {28'h0, db_estado}, 32'h0);
        echo = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        repeat (4) @(posedge clock);
        #1 check("post_reset", {30'h0, pronto, erro}, 32'h0);

        q.push_back(mk(24'h001234, 7, 12, 1, 1'b0));
        medicao(5, 12, 0, 0, 40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
